// File: rtl/round_scheduler_pkg.sv
// Shared definitions for the round scheduler: FSM encodings, round-length and
// hint-threshold tables, and the saturating score add.
package game_defs;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RUN        = 2'd1,
    S_HOLD       = 2'd2,
    S_MATCH_OVER = 2'd3
  } state_e;

  localparam logic [6:0] SCORE_MAX = 7'd99;

  // Indexed by cfg_time: 30/60/90/120 seconds.
  localparam logic [6:0] ROUND_SECS [4] = '{7'd30, 7'd60, 7'd90, 7'd120};

  // Hint release points per round length; the fourth slot is never reached.
  localparam logic [6:0] HINT_THRESH [4][4] = '{
    '{7'd22, 7'd15, 7'd7,  7'd0},
    '{7'd45, 7'd30, 7'd15, 7'd0},
    '{7'd67, 7'd45, 7'd22, 7'd0},
    '{7'd90, 7'd60, 7'd30, 7'd0}
  };

  function automatic logic [6:0] score_add(input logic [6:0] score, input logic [2:0] pts);
    logic [7:0] sum;
    sum = {1'b0, score} + {5'd0, pts};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[6:0];
  endfunction

endpackage

// File: rtl/round_scheduler_countdown.sv
// Per-round seconds counter with hint release and timeout pulses.
module round_countdown
  import game_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [6:0] load_secs_i,
  input  logic [1:0] time_sel_i,
  input  logic [1:0] max_hints_i,
  input  logic       run_i,
  input  logic       tick_i,
  output logic [6:0] seconds_left_o,
  output logic [2:0] hint_level_o,
  output logic       timer_done_o,
  output logic       hint_start_o,
  output logic       expire_o
);

  logic [6:0] secs_q, secs_d;
  logic [2:0] hint_q;
  logic       td_q, hs_q;
  logic       step, hint_hit;

  assign step     = run_i & tick_i & (secs_q != 7'd0);
  assign secs_d   = secs_q - 7'd1;
  assign expire_o = step & (secs_d == 7'd0);
  // Thresholds are crossed in order, so only the next unreleased one is compared.
  assign hint_hit = step & (hint_q < {1'b0, max_hints_i})
                  & (secs_d == HINT_THRESH[time_sel_i][hint_q[1:0]]);

  always_ff @(posedge clk) begin
    if (reset) begin
      secs_q <= '0;
      hint_q <= '0;
      td_q   <= 1'b0;
      hs_q   <= 1'b0;
    end else begin
      td_q <= expire_o;
      hs_q <= hint_hit;
      if (clear_i) begin
        secs_q <= '0;
        hint_q <= '0;
      end else if (load_i) begin
        secs_q <= load_secs_i;
        hint_q <= '0;
      end else if (step) begin
        secs_q <= secs_d;
        if (hint_hit) hint_q <= hint_q + 3'd1;
      end
    end
  end

  assign seconds_left_o = secs_q;
  assign hint_level_o   = hint_q;
  assign timer_done_o   = td_q;
  assign hint_start_o   = hs_q;

endmodule

// File: rtl/round_scheduler.sv
// Match-level scheduler: round FSM, team rotation, scoring and winner selection.
module round_scheduler
  import game_defs::*;
#(
  parameter int NUM_ROUNDS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       round_active,
  input  logic       word_correct,
  input  logic [1:0] cfg_teams,
  input  logic [1:0] cfg_diff,
  input  logic [1:0] cfg_time,
  input  logic       match_clear,
  output logic       timer_done,
  output logic       hint_start,
  output logic [2:0] hint_level,
  output logic [6:0] seconds_left,
  output logic [1:0] active_team,
  output logic [6:0] score0,
  output logic [6:0] score1,
  output logic [6:0] score2,
  output logic [6:0] score3,
  output logic [3:0] round_count,
  output logic       match_over,
  output logic [1:0] winner,
  output logic       tie,
  output state_e     state_dbg
);

  state_e     state_q;
  logic [1:0] teams_q, diff_q, time_q, active_team_q, winner_q;
  logic [3:0] round_count_q, rounds_d;
  logic [6:0] score_q [4];
  logic       ra_q, match_over_q, tie_q;
  logic       load, run, expire;
  logic [2:0] n_teams;
  logic [1:0] next_team, win_c;
  logic       tie_c;
  logic [6:0] best;

  assign load      = (state_q == S_IDLE) & round_active & ~ra_q & ~match_clear;
  // A correct guess or an abort freezes the clock, so neither can also time out.
  assign run       = (state_q == S_RUN) & round_active & ~word_correct & ~match_clear;
  assign n_teams   = (teams_q == 2'd0) ? 3'd2 : (teams_q == 2'd1) ? 3'd3 : 3'd4;
  assign next_team = ({1'b0, active_team_q} == n_teams - 3'd1) ? 2'd0 : active_team_q + 2'd1;
  assign rounds_d  = round_count_q + 4'd1;

  round_countdown u_countdown (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (match_clear),
    .load_i         (load),
    .load_secs_i    (ROUND_SECS[cfg_time]),
    .time_sel_i     (time_q),
    .max_hints_i    (2'd3 - diff_q),
    .run_i          (run),
    .tick_i         (tick_1hz),
    .seconds_left_o (seconds_left),
    .hint_level_o   (hint_level),
    .timer_done_o   (timer_done),
    .hint_start_o   (hint_start),
    .expire_o       (expire)
  );

  always_comb begin
    best  = score_q[0];
    win_c = 2'd0;
    tie_c = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (3'(i) < n_teams) begin
        if (score_q[i] > best) begin
          best  = score_q[i];
          win_c = 2'(i);
          tie_c = 1'b0;
        end else if (score_q[i] == best) begin
          tie_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      teams_q       <= '0;
      diff_q        <= '0;
      time_q        <= '0;
      active_team_q <= '0;
      round_count_q <= '0;
      ra_q          <= 1'b0;
      match_over_q  <= 1'b0;
      winner_q      <= '0;
      tie_q         <= 1'b0;
      for (int i = 0; i < 4; i++) score_q[i] <= '0;
    end else begin
      ra_q <= round_active;
      if (match_clear) begin
        state_q       <= S_IDLE;
        active_team_q <= '0;
        round_count_q <= '0;
        match_over_q  <= 1'b0;
        winner_q      <= '0;
        tie_q         <= 1'b0;
        for (int i = 0; i < 4; i++) score_q[i] <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (load) begin
            teams_q <= cfg_teams;
            diff_q  <= cfg_diff;
            time_q  <= cfg_time;
            state_q <= S_RUN;
          end
          S_RUN: begin
            if (!round_active) begin
              state_q <= S_HOLD;
            end else if (word_correct) begin
              score_q[active_team_q] <= score_add(score_q[active_team_q], 3'd4 - hint_level);
              state_q <= S_HOLD;
            end else if (expire) begin
              state_q <= S_HOLD;
            end
          end
          S_HOLD: if (!round_active) begin
            active_team_q <= next_team;
            round_count_q <= rounds_d;
            if (rounds_d == 4'(NUM_ROUNDS)) begin
              state_q      <= S_MATCH_OVER;
              match_over_q <= 1'b1;
              winner_q     <= win_c;
              tie_q        <= tie_c;
            end else begin
              state_q <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign active_team = active_team_q;
  assign round_count = round_count_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;
  assign tie         = tie_q;
  assign score0      = score_q[0];
  assign score1      = score_q[1];
  assign score2      = score_q[2];
  assign score3      = score_q[3];
  assign state_dbg   = state_q;

endmodule
